// File: rtl/sccb_cam_slave.sv
// SCCB/I2C device-side responder: decodes 3-phase register writes into a one-clock
// write strobe and serves sequential/random reads through a request/data port.
module sccb_cam_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WD, WD_ACK, RD, RD_MACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
  logic                   sclHist_q, sdaHist_q;
  logic                   sclS, sdaS;
  logic                   sclRise, sclFall, startEv, stopEv;

  state_t      state_q, state_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        loadTx_q, loadTx_d;
  logic        sdaOe_q, sdaOe_d;
  logic        wrEn_q, wrEn_d;
  logic [15:0] wrAddr_q, wrAddr_d;
  logic [7:0]  wrData_q, wrData_d;
  logic        rdReq_q, rdReq_d;
  logic [15:0] rdAddr_q, rdAddr_d;
  logic        busy_q, busy_d;

  logic [7:0]  byteNow;
  logic        byteDone;
  logic        addrMatch;

  // Idle bus is high, so the synchronizers reset to 1 to avoid a false START out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sclHist_q <= 1'b1;
      sdaHist_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
      sclHist_q <= sclS;
      sdaHist_q <= sdaS;
    end
  end

  assign sclS    = sclSync_q[SYNC_STAGES-1];
  assign sdaS    = sdaSync_q[SYNC_STAGES-1];
  assign sclRise = sclS & ~sclHist_q;
  assign sclFall = ~sclS & sclHist_q;
  assign startEv = sclS & sclHist_q & sdaHist_q & ~sdaS;
  assign stopEv  = sclS & sclHist_q & ~sdaHist_q & sdaS;

  assign byteNow   = {shift_q, sdaS};
  assign byteDone  = (bitCnt_q == 4'd8);
  assign addrMatch = (byteNow[7:1] == DEV_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    if (startEv) begin
      state_d  = DEV;
      bitCnt_d = '0;
    end else if (stopEv) begin
      state_d  = IDLE;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        DEV, AH, AL, WD: begin
          if (sclRise && !byteDone) begin
            bitCnt_d = bitCnt_q + 4'd1;
            if (state_q == DEV && bitCnt_q == 4'd7 && !addrMatch) begin
              state_d  = IGNORE;
              bitCnt_d = '0;
            end
          end else if (sclFall && byteDone) begin
            bitCnt_d = '0;
            case (state_q)
              DEV:     state_d = DEV_ACK;
              AH:      state_d = AH_ACK;
              AL:      state_d = AL_ACK;
              default: state_d = WD_ACK;
            endcase
          end
        end
        DEV_ACK: begin
          if (sclFall) begin
            bitCnt_d = '0;
            state_d  = shift_q[0] ? RD : AH;
          end
        end
        AH_ACK: if (sclFall) state_d = AL;
        AL_ACK: if (sclFall) state_d = WD;
        WD_ACK: if (sclFall) state_d = WD;
        RD: begin
          if (sclRise && !byteDone) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && byteDone) begin
            bitCnt_d = '0;
            state_d  = RD_MACK;
          end
        end
        // bitCnt doubles as a flag: 1 means the master ACKed and another byte follows.
        RD_MACK: begin
          if (sclRise && bitCnt_q == 4'd0) begin
            if (!sdaS) bitCnt_d = 4'd1;
            else       state_d  = IGNORE;
          end else if (sclFall && bitCnt_q == 4'd1) begin
            bitCnt_d = '0;
            state_d  = RD;
          end
        end
        default: begin
          state_d  = state_q;
          bitCnt_d = bitCnt_q;
        end
      endcase
    end
  end

  always_comb begin
    sdaOe_d  = sdaOe_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    rdReq_d  = 1'b0;
    rdAddr_d = rdAddr_q;
    busy_d   = busy_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    loadTx_d = rdReq_q;
    if (loadTx_q) tx_d = rd_data;
    if (wrEn_q)   rdAddr_d = rdAddr_q + 16'd1;
    if (startEv) begin
      sdaOe_d = 1'b0;
    end else if (stopEv) begin
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        DEV, AH, AL, WD: begin
          if (sclRise && !byteDone) begin
            shift_d = byteNow[6:0];
            if (bitCnt_q == 4'd7) begin
              case (state_q)
                DEV: begin
                  if (addrMatch) begin
                    busy_d  = 1'b1;
                    rdReq_d = byteNow[0];
                  end
                end
                AH: rdAddr_d[15:8] = byteNow;
                AL: rdAddr_d[7:0]  = byteNow;
                default: begin
                  wrEn_d   = 1'b1;
                  wrAddr_d = rdAddr_q;
                  wrData_d = byteNow;
                end
              endcase
            end
          end else if (sclFall && byteDone) begin
            sdaOe_d = 1'b1;
          end
        end
        DEV_ACK: begin
          if (sclFall) begin
            if (shift_q[0]) begin
              sdaOe_d = ~tx_q[7];
              tx_d    = {tx_q[6:0], 1'b0};
            end else begin
              sdaOe_d = 1'b0;
            end
          end
        end
        AH_ACK, AL_ACK, WD_ACK: if (sclFall) sdaOe_d = 1'b0;
        RD: begin
          if (sclFall) begin
            if (byteDone) begin
              sdaOe_d = 1'b0;
            end else begin
              sdaOe_d = ~tx_q[7];
              tx_d    = {tx_q[6:0], 1'b0};
            end
          end
        end
        RD_MACK: begin
          if (sclRise && bitCnt_q == 4'd0 && !sdaS) begin
            rdAddr_d = rdAddr_q + 16'd1;
            rdReq_d  = 1'b1;
          end else if (sclFall && bitCnt_q == 4'd1) begin
            sdaOe_d = ~tx_q[7];
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end
        default: sdaOe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      tx_q     <= '0;
      loadTx_q <= 1'b0;
      sdaOe_q  <= 1'b0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      rdReq_q  <= 1'b0;
      rdAddr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      loadTx_q <= loadTx_d;
      sdaOe_q  <= sdaOe_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      rdReq_q  <= rdReq_d;
      rdAddr_q <= rdAddr_d;
      busy_q   <= busy_d;
    end
  end

  assign sda_oe  = sdaOe_q;
  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign rd_req  = rdReq_q;
  assign rd_addr = rdAddr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sccb_cam_slave.sv
// Bench for sccb_cam_slave: an SCCB master drives directed and random transactions,
// and a register-file model supplies read data and predicts writes and pointer motion.
module tb_sccb_cam_slave;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sdaDrv = 1'b1;
  logic        sdaLine;
  logic        sdaOe, wrEn, rdReq, busy;
  logic [15:0] wrAddr, rdAddr;
  logic [7:0]  wrData;
  logic [7:0]  rdDataReg = 8'h00;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0]  regFile [0:65535];
  logic [7:0]  txData  [0:3];
  logic [23:0] wrLog [$];
  logic [15:0] rdLog [$];
  int          oeCount   = 0;
  int          busyCount = 0;

  assign sdaLine = sdaDrv & ~sdaOe;

  sccb_cam_slave #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl),
    .sda_i   (sdaLine),
    .sda_oe  (sdaOe),
    .wr_en   (wrEn),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .rd_req  (rdReq),
    .rd_addr (rdAddr),
    .rd_data (rdDataReg),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Register-file model: read data is valid only on the clock after rd_req.
  always @(posedge clk) rdDataReg <= rdReq ? regFile[rdAddr] : 8'h00;

  always @(negedge clk) begin
    if (wrEn)  wrLog.push_back({wrAddr, wrData});
    if (rdReq) rdLog.push_back(rdAddr);
    if (sdaOe) oeCount <= oeCount + 1;
    if (busy)  busyCount <= busyCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic busStart();
    sdaDrv = 1'b1; waitQ();
    scl = 1'b1;    waitQ();
    sdaDrv = 1'b0; waitQ();
    scl = 1'b0;    waitQ();
  endtask

  task automatic busStop();
    sdaDrv = 1'b0; waitQ();
    scl = 1'b1;    waitQ();
    sdaDrv = 1'b1; waitQ();
    waitQ();
  endtask

  task automatic busBit(input logic b, output logic s);
    sdaDrv = b; waitQ();
    scl = 1'b1; waitQ();
    s = sdaLine; waitQ();
    scl = 1'b0; waitQ();
  endtask

  task automatic applyStimulus(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) busBit(b[i], s);
    busBit(1'b1, s);
    ack = ~s;
  endtask

  task automatic readByte(input logic mAck, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      busBit(1'b1, s);
      d[i] = s;
    end
    busBit(~mAck, s);
  endtask

  function automatic logic [23:0] wrEntry(input int idx);
    return (idx < wrLog.size()) ? wrLog[idx] : 24'hFFFFFF;
  endfunction

  function automatic logic [15:0] rdEntry(input int idx);
    return (idx < rdLog.size()) ? rdLog[idx] : 16'hDEAD;
  endfunction

  task automatic writeTxn(input logic [15:0] a, input int n, input string tag);
    logic ack;
    int   base;
    base = wrLog.size();
    busStart();
    applyStimulus(8'h78, ack);
    checkOutput({tag, " dev ack"}, 32'(ack), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    applyStimulus(a[15:8], ack);
    checkOutput({tag, " addr-hi ack"}, 32'(ack), 32'd1);
    applyStimulus(a[7:0], ack);
    checkOutput({tag, " addr-lo ack"}, 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      applyStimulus(txData[k], ack);
      checkOutput({tag, " data ack"}, 32'(ack), 32'd1);
    end
    busStop();
    checkOutput({tag, " write count"}, 32'(wrLog.size() - base), 32'(n));
    for (int k = 0; k < n; k++)
      checkOutput({tag, " write entry"}, {8'h00, wrEntry(base + k)},
                  {8'h00, 16'(a + 16'(k)), txData[k]});
    checkOutput({tag, " pointer"}, {16'h0, rdAddr}, {16'h0, 16'(a + 16'(n))});
    checkOutput({tag, " busy after stop"}, 32'(busy), 32'd0);
  endtask

  task automatic readTxn(input logic [15:0] b, input int m, input string tag);
    logic       ack;
    logic [7:0] d;
    int         base;
    base = rdLog.size();
    busStart();
    applyStimulus(8'h78, ack);
    applyStimulus(b[15:8], ack);
    applyStimulus(b[7:0], ack);
    busStart();
    applyStimulus(8'h79, ack);
    checkOutput({tag, " read dev ack"}, 32'(ack), 32'd1);
    for (int k = 0; k < m; k++) begin
      readByte(k < m - 1, d);
      checkOutput({tag, " read byte"}, {24'h0, d}, {24'h0, regFile[16'(b + 16'(k))]});
    end
    checkOutput({tag, " sda released after nack"}, 32'(sdaOe), 32'd0);
    busStop();
    checkOutput({tag, " rd_req count"}, 32'(rdLog.size() - base), 32'(m));
    for (int k = 0; k < m; k++)
      checkOutput({tag, " rd_req addr"}, {16'h0, rdEntry(base + k)}, {16'h0, 16'(b + 16'(k))});
    checkOutput({tag, " pointer"}, {16'h0, rdAddr}, {16'h0, 16'(b + 16'(m - 1))});
    checkOutput({tag, " busy after stop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] devW;
    int         wrBase, rdBase, oeBase, busyBase, n;

    for (int i = 0; i < 65536; i++) regFile[i] = 8'($urandom);
    regFile[16'h300A] = 8'h56;
    regFile[16'h300B] = 8'h40;

    repeat (4) @(negedge clk);
    checkOutput("reset sda_oe", 32'(sdaOe), 32'd0);
    checkOutput("reset wr_en", 32'(wrEn), 32'd0);
    checkOutput("reset rd_req", 32'(rdReq), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rd_addr", {16'h0, rdAddr}, 32'd0);
    checkOutput("reset wr_addr/data", {8'h0, wrAddr, wrData}, 32'd0);
    rst_n = 1'b1;
    waitQ();

    $display("[TB] single write");
    txData[0] = 8'hA5;
    writeTxn(16'h3108, 1, "single");

    $display("[TB] burst write with wrap");
    txData[0] = 8'h11; txData[1] = 8'h22;
    writeTxn(16'hFFFF, 2, "wrap");

    $display("[TB] random read");
    readTxn(16'h300A, 2, "rdread");

    $display("[TB] wrong device");
    wrBase = wrLog.size(); rdBase = rdLog.size(); oeBase = oeCount; busyBase = busyCount;
    busStart();
    applyStimulus(8'h42, ack);
    checkOutput("wrongdev ack", 32'(ack), 32'd0);
    applyStimulus(8'h31, ack);
    checkOutput("wrongdev 2nd ack", 32'(ack), 32'd0);
    busStop();
    checkOutput("wrongdev sda_oe activity", 32'(oeCount - oeBase), 32'd0);
    checkOutput("wrongdev writes", 32'(wrLog.size() - wrBase), 32'd0);
    checkOutput("wrongdev reads", 32'(rdLog.size() - rdBase), 32'd0);
    checkOutput("wrongdev busy activity", 32'(busyCount - busyBase), 32'd0);

    $display("[TB] abort with repeated start");
    wrBase = wrLog.size();
    busStart();
    applyStimulus(8'h78, ack);
    applyStimulus(8'h31, ack);
    applyStimulus(8'h08, ack);
    busBit(1'b1, s); busBit(1'b0, s); busBit(1'b1, s); busBit(1'b0, s);
    busStart();
    applyStimulus(8'h78, ack);
    applyStimulus(8'h30, ack);
    applyStimulus(8'h08, ack);
    applyStimulus(8'h02, ack);
    checkOutput("abort data ack", 32'(ack), 32'd1);
    busStop();
    checkOutput("abort write count", 32'(wrLog.size() - wrBase), 32'd1);
    checkOutput("abort write entry", {8'h0, wrEntry(wrBase)}, {8'h0, 24'h300802});

    $display("[TB] reset during ACK");
    devW = 8'h78;
    busStart();
    for (int i = 7; i >= 0; i--) busBit(devW[i], s);
    n = 0;
    while (sdaOe !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ack driven before reset", 32'(sdaOe), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset sda_oe", 32'(sdaOe), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset rd_addr", {16'h0, rdAddr}, 32'd0);
    checkOutput("async reset wr_addr/data", {8'h0, wrAddr, wrData}, 32'd0);
    checkOutput("async reset strobes", {30'h0, wrEn, rdReq}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitQ();
    txData[0] = 8'h5A;
    writeTxn(16'h4300, 1, "post-reset");

    $display("[TB] randomized transactions");
    for (int it = 0; it < 5; it++) begin
      logic [15:0] a;
      int          cnt;
      a   = 16'($urandom);
      cnt = $urandom_range(1, 3);
      for (int k = 0; k < cnt; k++) txData[k] = 8'($urandom);
      writeTxn(a, cnt, "rand write");
      a   = (it == 0) ? 16'hFFFE : 16'($urandom);
      cnt = $urandom_range(1, 3);
      readTxn(a, cnt, "rand read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sccb_cam_slave.md
Name: sccb_cam_slave

Overview:
- SCCB/I2C responder for the camera register interface: the device end of the 3-phase write (device address, 16-bit register address, 8-bit data) that the OV5640 init sequencer issues.
- Decodes bus traffic into a single-cycle register-write strobe and serves register reads through a request/data port.
- Sits behind a camera register-file model for closed-loop simulation of the config path. Also usable as an on-FPGA debug target on the sensor bus.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit device address (8-bit write form 0x78, read form 0x79).
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  bus clock, asynchronous.
- sda_i  input  1  bus data, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  output  1  one-clk register-write strobe.
- wr_addr  output  16  register address qualified by wr_en.
- wr_data  output  8  register data qualified by wr_en.
- rd_req  output  1  one-clk read request for the address on rd_addr.
- rd_addr  output  16  current register pointer.
- rd_data  input  8  read data, valid on the clk after rd_req.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, FSM=IDLE, bit counter=0.
- Reset asserted mid-transfer releases SDA immediately and discards any partial byte.
- Input synchronization:
  - scl_i and sda_i pass through SYNC_STAGES flops, plus one history flop each for edge detection.
  - Events are decoded on the synchronized signals.
- Bus events:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on the SCL rising edge.
  - sda_oe changes only on an SCL falling edge, one clk after it is detected.
- FSM states: IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WD, WD_ACK, RD, RD_MACK, IGNORE.
- Event priority:
  - START in any state goes to DEV with bit counter 0. No write is issued for a partial byte. This covers repeated start.
  - STOP in any state goes to IDLE, releases SDA and clears busy.
  - STOP/START take priority over bit sampling in the same clk.
- DEV state: shift 8 bits, MSB first.
  - Match on bits[7:1]==DEV_ADDR: drive ACK during the 9th SCL, set busy.
  - R/W=0 then goes to AH.
  - R/W=1 pulses rd_req on the 8th-bit rising edge and loads rd_data into the transmit shifter one clk later, then goes to RD.
  - Mismatch: no ACK (SDA released), go to IGNORE until the next START/STOP.
- Write path:
  - AH captures rd_addr[15:8]; AL captures rd_addr[7:0]. Both are ACKed.
  - WD: on the 8th-bit rising edge, wr_en=1 for exactly one clk, with wr_addr=rd_addr and wr_data=byte.
  - rd_addr increments the clk after wr_en, wrapping 16'hFFFF to 16'h0000. Then ACK and return to WD for the next byte.
- Read path:
  - RD drives ~bit onto sda_oe, MSB first, changing on SCL falling edges.
  - After the 8th bit, release SDA for the master ACK (RD_MACK) and sample it on the SCL rising edge.
  - Master ACK (SDA low): increment rd_addr, pulse rd_req, reload the shifter, go to RD.
  - Master NACK: go to IGNORE, keep SDA released.
- A read begun directly after a write-address phase (repeated START) returns the byte at the written pointer. This is the SCCB random-read form.
- SDA is never driven while SCL is high except to hold ACK/data already set on the prior falling edge.

Test Plan:
- Single write: START, 0x78, 0x31, 0x08, 0xA5, STOP -> 4 ACKs; one wr_en with wr_addr=16'h3108, wr_data=8'hA5; busy low after STOP.
- Burst write with wrap: START 0x78 FF FF 11 22 STOP -> wr_en twice, (FFFF,11) then (0000,22); rd_addr=16'h0001 at end.
- Random read: write phase 0x78 30 0A, repeated START, 0x79; model returns 0x56 then 0x40; master ACK then NACK -> rd_req with rd_addr 300A then 300B; bus bits 0x56, 0x40; SDA released after NACK.
- Wrong device: START 0x42 ... STOP -> no ACK on the 9th bit; sda_oe stays 0 throughout; no wr_en, no rd_req; busy stays 0.
- Abort: START 0x78 31 08, 4 data bits, repeated START, 0x78 30 08 02 STOP -> no write for the partial byte; single wr_en (3008,02).
- Reset mid-ACK: assert rst_n low while sda_oe=1 -> sda_oe=0 in the same cycle, all outputs at reset values; next full write decodes correctly.
